// File: rtl/riscv_mem_stage.sv
// RISCV-Mini-2 memory stage: issues loads/stores over a req/ack bus and drives the MEM/WB bundle.
// Optional access timeout (bus_fault) is enabled by defining RISCV_MEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | accept next EX/MEM instruction; non-memory and faulting ops retire next edge
// ACCESS | dmem request outstanding, outputs held until ack (or timeout)
module riscv_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  wb_src_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_pc_plus4,
    output logic [1:0]  wb_src,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        access_fault,
    output logic        bus_fault
);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state_q, state_d;

    logic [1:0]  off;
    logic        is_mem, bad_f3, misaligned, fault, accept, expire, done;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [2:0]  lat_f3;
    logic        lat_read, lat_rw;
    logic [31:0] lat_alu, lat_pc;
    logic [1:0]  lat_src;
    logic [4:0]  lat_rd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign off = alu_result[1:0];

    // Fault decode; store funct3 >= 011 is illegal, loads reject 011/110/111
    always_comb begin
        is_mem     = mem_read | mem_write;
        bad_f3     = mem_read ? ((&funct3[1:0]) | (&funct3[2:1]))
                              : (funct3[2] | (&funct3[1:0]));
        misaligned = ((funct3[1:0] == 2'b01) & off[0]) |
                     ((funct3[1:0] == 2'b10) & (off != 2'b00));
        fault      = ex_valid & is_mem & ((mem_read & mem_write) | bad_f3 | misaligned);
        accept     = ex_valid & is_mem & ~fault;
    end

    always_comb begin
        st_wdata = store_data;
        st_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_be    = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_be    = off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_half = lat_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_alu[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        case (lat_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    assign done = dmem_ack | expire;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = accept;
                if (accept) state_d = ACCESS;
            end
            ACCESS: begin
                stall = ~done;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'b0;
            dmem_wdata    <= 32'b0;
            dmem_be       <= 4'b0;
            wb_valid      <= 1'b0;
            wb_alu_result <= 32'b0;
            wb_mem_data   <= 32'b0;
            wb_pc_plus4   <= 32'b0;
            wb_src        <= 2'b0;
            wb_rd         <= 5'b0;
            wb_reg_write  <= 1'b0;
            access_fault  <= 1'b0;
            lat_f3        <= 3'b0;
            lat_read      <= 1'b0;
            lat_rw        <= 1'b0;
            lat_alu       <= 32'b0;
            lat_pc        <= 32'b0;
            lat_src       <= 2'b0;
            lat_rd        <= 5'b0;
        end else begin
            wb_valid     <= 1'b0;
            access_fault <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    lat_f3     <= funct3;
                    lat_read   <= mem_read;
                    lat_rw     <= reg_write_in;
                    lat_alu    <= alu_result;
                    lat_pc     <= pc_plus4;
                    lat_src    <= wb_src_in;
                    lat_rd     <= rd_in;
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write;
                    dmem_addr  <= {alu_result[31:2], 2'b00};
                    dmem_wdata <= mem_write ? st_wdata : 32'b0;
                    dmem_be    <= mem_write ? st_be : 4'b1111;
                end else if (ex_valid) begin
                    wb_valid      <= 1'b1;
                    wb_alu_result <= alu_result;
                    wb_mem_data   <= 32'b0;
                    wb_pc_plus4   <= pc_plus4;
                    wb_src        <= wb_src_in;
                    wb_rd         <= rd_in;
                    wb_reg_write  <= reg_write_in & ~fault;
                    access_fault  <= fault;
                end
            end else if (done) begin
                // ack wins over a simultaneous timeout
                dmem_req      <= 1'b0;
                wb_valid      <= 1'b1;
                wb_alu_result <= lat_alu;
                wb_mem_data   <= (dmem_ack & lat_read) ? ld_ext : 32'b0;
                wb_pc_plus4   <= lat_pc;
                wb_src        <= lat_src;
                wb_rd         <= lat_rd;
                wb_reg_write  <= lat_rw & dmem_ack;
            end
        end
    end

`ifdef RISCV_MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)                    tmo_cnt <= '0;
        else if (state_q == IDLE)      tmo_cnt <= TMO_LOAD;
        else if (tmo_cnt != '0)        tmo_cnt <= tmo_cnt - 1'b1;
    end

    assign expire = (state_q == ACCESS) && (tmo_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) bus_fault <= 1'b0;
        else        bus_fault <= expire & ~dmem_ack;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign expire    = 1'b0;
    assign bus_fault = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Bench for riscv_mem_stage: vector table of loads/stores/faults, MEM/WB scoreboard, reset corner.
module tb_riscv_mem_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n, ex_valid, mem_read, mem_write, reg_write_in, dmem_ack;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data, pc_plus4, dmem_rdata;
    logic [1:0]  wb_src_in;
    logic [4:0]  rd_in;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write, access_fault, bus_fault;
    logic [31:0] dmem_addr, dmem_wdata, wb_alu_result, wb_mem_data, wb_pc_plus4;
    logic [3:0]  dmem_be;
    logic [1:0]  wb_src;
    logic [4:0]  wb_rd;

    riscv_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .pc_plus4(pc_plus4), .wb_src_in(wb_src_in),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
        .wb_mem_data(wb_mem_data), .wb_pc_plus4(wb_pc_plus4), .wb_src(wb_src),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .access_fault(access_fault),
        .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  src;
        logic        rw;
        logic        fault;
        logic [31:0] exp_mem;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic        rw;
        logic        af;
        logic        bf;
    } exp_t;

    exp_t sb[$];
    vec_t tv[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dmem_ctl"}, {29'b0, dmem_req, dmem_we, 1'b0} | {28'b0, dmem_be}, 32'h0);
        chk({tag, "_dmem_addr"}, dmem_addr, 32'h0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 32'h0);
        chk({tag, "_wb_ctl"}, {20'b0, wb_valid, wb_src, wb_rd, wb_reg_write, access_fault, bus_fault, stall}, 32'h0);
        chk({tag, "_wb_alu"}, wb_alu_result, 32'h0);
        chk({tag, "_wb_mem"}, wb_mem_data, 32'h0);
        chk({tag, "_wb_pc"}, wb_pc_plus4, 32'h0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: wb_valid=1 got, none expected");
            end else begin
                e = sb.pop_front();
                chk("wb_alu_result", wb_alu_result, e.alu);
                chk("wb_mem_data", wb_mem_data, e.mem);
                chk("wb_pc_plus4", wb_pc_plus4, e.pc);
                chk("wb_src", {30'b0, wb_src}, {30'b0, e.src});
                chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
                chk("access_fault", {31'b0, access_fault}, {31'b0, e.af});
                chk("bus_fault", {31'b0, bus_fault}, {31'b0, e.bf});
            end
        end else if (rst_n === 1'b1 && (access_fault !== 1'b0 || bus_fault !== 1'b0)) begin
            checks++;
            errors++;
            $display("FAIL stray_fault_pulse: access_fault=%b bus_fault=%b without wb_valid", access_fault, bus_fault);
        end
    end

    task automatic clear_inputs();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        exp_t  e;
        logic  legal;
        int    stall_cnt;
        string p;
        p     = $sformatf("op%0d", idx);
        legal = (v.mr | v.mw) & ~v.fault;
        e.alu = v.addr;
        e.mem = v.fault ? 32'h0 : v.exp_mem;
        e.pc  = 32'h1000 + 32'(idx * 4);
        e.src = v.src;
        e.rd  = 5'(idx + 1);
        e.rw  = v.rw & ~v.fault;
        e.af  = v.fault;
        e.bf  = 1'b0;

        ex_valid     = 1'b1;
        mem_read     = v.mr;
        mem_write    = v.mw;
        funct3       = v.f3;
        alu_result   = v.addr;
        store_data   = v.sdata;
        pc_plus4     = e.pc;
        wb_src_in    = v.src;
        rd_in        = e.rd;
        reg_write_in = v.rw;
        sb.push_back(e);

        @(negedge clk);
        chk({p, "_stall_accept"}, {31'b0, stall}, {31'b0, legal});
        @(posedge clk); #1;
        clear_inputs();
        if (legal) begin
            stall_cnt = 1;
            for (int w = 0; w < v.waits; w++) begin
                dmem_rdata = $urandom;
                @(negedge clk);
                chk({p, "_req_wait"}, {31'b0, dmem_req}, 32'h1);
                if (stall === 1'b1) stall_cnt++;
                @(posedge clk); #1;
            end
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
            @(negedge clk);
            chk({p, "_req"}, {31'b0, dmem_req}, 32'h1);
            chk({p, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
            chk({p, "_we"}, {31'b0, dmem_we}, {31'b0, v.mw});
            chk({p, "_be"}, {28'b0, dmem_be}, {28'b0, v.exp_be});
            if (v.mw) chk({p, "_wdata"}, dmem_wdata, v.exp_wdata);
            chk({p, "_stall_ack"}, {31'b0, stall}, 32'h0);
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            chk({p, "_stall_cycles"}, 32'(stall_cnt), 32'(1 + v.waits));
        end
        @(negedge clk);
        chk({p, "_wb_latency"}, {31'b0, wb_valid}, 32'h1);
        chk({p, "_req_low"}, {31'b0, dmem_req}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        clear_inputs();
        funct3       = 3'b0;
        alu_result   = 32'h0;
        store_data   = 32'h0;
        pc_plus4     = 32'h0;
        wb_src_in    = 2'b0;
        rd_in        = 5'b0;
        reg_write_in = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;

        //          mr    mw    f3      addr          sdata         rdata         w  src    rw    flt   exp_mem       be       wdata
        tv[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        0, 2'b00, 1'b1, 1'b0, 32'h0,        4'hF, 32'h0};
        tv[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 3, 2'b01, 1'b1, 1'b0, 32'hFFFF_FF80, 4'hF, 32'h0};
        tv[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 3, 2'b01, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0};
        tv[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        0, 2'b00, 1'b0, 1'b0, 32'h0,        4'hC, 32'hBEEF_BEEF};
        tv[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0,        32'h0,        0, 2'b01, 1'b1, 1'b1, 32'h0,        4'hF, 32'h0};
        tv[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_FF7F, 1, 2'b01, 1'b1, 1'b0, 32'hFFFF_80FF, 4'hF, 32'h0};
        tv[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_8001, 0, 2'b01, 1'b1, 1'b0, 32'h0000_8001, 4'hF, 32'h0};
        tv[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 2, 2'b01, 1'b1, 1'b0, 32'hCAFE_F00D, 4'hF, 32'h0};
        tv[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h1234_5678, 32'h0,        0, 2'b00, 1'b0, 1'b0, 32'h0,        4'h2, 32'h7878_7878};
        tv[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hA5A5_5A5A, 32'h0,        1, 2'b00, 1'b0, 1'b0, 32'h0,        4'hF, 32'hA5A5_5A5A};
        tv[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 2'b01, 1'b1, 1'b1, 32'h0,        4'hF, 32'h0};
        tv[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 2'b01, 1'b1, 1'b1, 32'h0,        4'hF, 32'h0};
        tv[12] = '{1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 2'b00, 1'b1, 1'b1, 32'h0,        4'hF, 32'h0};
        tv[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 2'b01, 1'b1, 1'b1, 32'h0,        4'hF, 32'h0};
        tv[14] = '{1'b0, 1'b0, 3'b000, 32'hABCD_0000, 32'h0,        32'h0,        0, 2'b10, 1'b1, 1'b0, 32'h0,        4'hF, 32'h0};
        tv[15] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 2'b01, 1'b1, 1'b0, 32'h0000_007F, 4'hF, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            run_op(tv[i], i);
        end

        // reset while a load is outstanding; the late ack must be dropped
        @(posedge clk); #1;
        ex_valid     = 1'b1;
        mem_read     = 1'b1;
        funct3       = 3'b010;
        alu_result   = 32'h0000_0400;
        pc_plus4     = 32'h0000_2000;
        rd_in        = 5'd7;
        reg_write_in = 1'b1;
        wb_src_in    = 2'b01;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("rst_req_before", {31'b0, dmem_req}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk_reset("rst_mid");
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rst_ack_ignored_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_ack_ignored_req", {31'b0, dmem_req}, 32'h0);

`ifdef RISCV_MEM_TIMEOUT_EN
        begin
            exp_t e;
            int   n;
            @(posedge clk); #1;
            ex_valid     = 1'b1;
            mem_read     = 1'b1;
            funct3       = 3'b010;
            alu_result   = 32'h0000_0500;
            pc_plus4     = 32'h0000_3000;
            rd_in        = 5'd9;
            reg_write_in = 1'b1;
            wb_src_in    = 2'b01;
            e = '{32'h0000_0500, 32'h0, 32'h0000_3000, 2'b01, 5'd9, 1'b0, 1'b0, 1'b1};
            sb.push_back(e);
            @(posedge clk); #1;
            clear_inputs();
            n = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (dmem_req !== 1'b1) break;
                n++;
            end
            chk("tmo_req_cycles", 32'(n), 32'(TMO));
            chk("tmo_stall_released", {31'b0, stall}, 32'h0);
            chk("tmo_wb_valid", {31'b0, wb_valid}, 32'h1);
        end
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
